// File: rtl/rr_incr_scheduler.sv
// Round-robin scheduler sharing one registered increment unit between NREQ requesters.
// state | meaning
// IDLE  | arbitrate pending requests, latch winner operand
// BUSY  | operand latched, waiting for hold low to compute result
// DONE  | result presented for one cycle, pointer rotates
module rr_incr_scheduler #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   req_data,
  input  logic                    hold,
  input  logic                    disable_error,
  output logic [NREQ-1:0]         gnt,
  output logic                    rsp_valid,
  output logic [IDW-1:0]          rsp_id,
  output logic [WIDTH-1:0]        rsp_data,
  output logic                    rsp_wrap,
  output logic                    err
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_nxt;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   win_id;
  logic             win_found;
  logic [IDW-1:0]   cur_id;
  logic [WIDTH-1:0] cur_op;
  logic             start, finish;
  logic [NREQ-1:0]  req_q, gnt_q, viol;

  // Scan from ptr upward; the explicit subtract keeps wrap correct for non-power-of-two NREQ.
  always_comb begin
    logic [IDW:0]   idx_ext;
    logic [IDW-1:0] idx;
    win_found = 1'b0;
    win_id    = '0;
    idx_ext   = '0;
    idx       = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx_ext = {1'b0, ptr} + (IDW+1)'(k);
      if (idx_ext >= (IDW+1)'(NREQ)) idx_ext = idx_ext - (IDW+1)'(NREQ);
      idx = idx_ext[IDW-1:0];
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win_id    = idx;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: if (win_found && !hold) begin
        start     = 1'b1;
        state_nxt = BUSY;
      end
      BUSY: if (!hold) begin
        finish    = 1'b1;
        state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr       <= '0;
      cur_id    <= '0;
      cur_op    <= '0;
      gnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      rsp_wrap  <= 1'b0;
    end else begin
      gnt       <= '0;
      rsp_valid <= 1'b0;
      if (start) begin
        cur_id <= win_id;
        cur_op <= req_data[win_id*WIDTH +: WIDTH];
        gnt    <= NREQ'(1) << win_id;
      end
      if (finish) begin
        rsp_valid <= 1'b1;
        rsp_id    <= cur_id;
        rsp_data  <= cur_op + 1'b1;
        rsp_wrap  <= &cur_op;
      end
      if (state == DONE) ptr <= (cur_id == IDW'(NREQ-1)) ? '0 : cur_id + 1'b1;
    end
  end

  // A request may fall in its grant cycle or the cycle after; any other fall is a withdrawal.
  assign viol = req_q & ~req & ~gnt & ~gnt_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      req_q <= '0;
      gnt_q <= '0;
      err   <= 1'b0;
    end else begin
      req_q <= req;
      gnt_q <= gnt;
      if (|viol && !disable_error) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rr_incr_scheduler.sv
// Directed bench for rr_incr_scheduler with a grant/response scoreboard.
module tb_rr_incr_scheduler;

  logic        clock;
  logic        reset_n;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic        hold;
  logic        disable_error;
  logic [3:0]  gnt;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_data;
  logic        rsp_wrap;
  logic        err;

  typedef struct {
    logic [1:0] id;
    logic [7:0] data;
    logic       wrap;
  } rsp_t;

  rsp_t       exp_rsp[$];
  logic [3:0] exp_gnt[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_gnt_cyc = 0;
  int exp_lat = 1;
  int c0, prev_g;

  rr_incr_scheduler #(.NREQ(4), .WIDTH(8)) dut (
    .clock(clock), .reset_n(reset_n), .req(req), .req_data(req_data),
    .hold(hold), .disable_error(disable_error), .gnt(gnt), .rsp_valid(rsp_valid),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_wrap(rsp_wrap), .err(err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_op(input int id, input logic [7:0] op);
    rsp_t e;
    e.id   = 2'(id);
    e.data = op + 8'd1;
    e.wrap = (op == 8'hFF);
    exp_gnt.push_back(4'b0001 << id);
    exp_rsp.push_back(e);
  endtask

  // Advance one clock, sample 1 ns later and score any grant/response.
  task automatic tick();
    rsp_t e;
    @(posedge clock);
    #1;
    cyc++;
    check("gnt_onehot0", 32'($onehot0(gnt)), 1);
    if (gnt !== 4'b0000) begin
      if (exp_gnt.size() == 0) check("gnt_unexpected", 32'(gnt), 0);
      else check("gnt", 32'(gnt), 32'(exp_gnt.pop_front()));
      last_gnt_cyc = cyc;
    end
    if (rsp_valid) begin
      if (exp_rsp.size() == 0) check("rsp_unexpected", 32'(rsp_valid), 0);
      else begin
        e = exp_rsp.pop_front();
        check("rsp_id", 32'(rsp_id), 32'(e.id));
        check("rsp_data", 32'(rsp_data), 32'(e.data));
        check("rsp_wrap", 32'(rsp_wrap), 32'(e.wrap));
        check("rsp_latency", cyc, last_gnt_cyc + exp_lat);
      end
    end
  endtask

  task automatic wait_gnt(input int n);
    bit got = 1'b0;
    for (int i = 0; i < n && !got; i++) begin
      tick();
      if (gnt !== 4'b0000) got = 1'b1;
    end
    check("gnt_wait", 32'(got), 1);
  endtask

  task automatic wait_rsp(input int n);
    bit got = 1'b0;
    for (int i = 0; i < n && !got; i++) begin
      tick();
      if (rsp_valid) got = 1'b1;
    end
    check("rsp_wait", 32'(got), 1);
  endtask

  initial begin
    reset_n = 1'b0; req = '0; req_data = '0; hold = 1'b0; disable_error = 1'b0;
    repeat (2) tick();
    check("rst_gnt", 32'(gnt), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_id", 32'(rsp_id), 0);
    check("rst_rsp_data", 32'(rsp_data), 0);
    check("rst_rsp_wrap", 32'(rsp_wrap), 0);
    check("rst_err", 32'(err), 0);
    reset_n = 1'b1;
    tick();

    // All four requesting: strict rotation 0,1,2,3,0
    req_data = {8'h30, 8'h20, 8'h10, 8'h00};
    req = 4'b1111;
    for (int k = 0; k < 5; k++) push_op(k % 4, 8'((k % 4) * 16));
    prev_g = 0;
    for (int k = 0; k < 5; k++) begin
      wait_gnt(6);
      if (k > 0) check("rotate_spacing", last_gnt_cyc - prev_g, 3);
      prev_g = last_gnt_cyc;
      if (k == 1) req[1] = 1'b0;
      if (k == 2) req[2] = 1'b0;
      if (k == 3) req[3] = 1'b0;
      if (k == 4) req[0] = 1'b0;
    end
    wait_rsp(3);
    check("rotate_drained", exp_rsp.size(), 0);
    check("rotate_err", 32'(err), 0);
    tick();

    // Single requester, minimum latency; ptr is 1 so this also exercises the wrap scan
    req_data[7:0] = 8'h41;
    req = 4'b0001;
    push_op(0, 8'h41);
    c0 = cyc;
    wait_gnt(3);
    check("single_gnt_lat", last_gnt_cyc, c0 + 1);
    req = 4'b0000;
    wait_rsp(3);
    tick();
    check("rsp_data_hold", 32'(rsp_data), 32'h42);
    check("rsp_id_hold", 32'(rsp_id), 0);

    // All-ones operand wraps to zero
    req_data[23:16] = 8'hFF;
    req = 4'b0100;
    push_op(2, 8'hFF);
    wait_gnt(3);
    req = 4'b0000;
    wait_rsp(3);
    tick();

    // Hold in BUSY for 4 cycles; operand change after capture must not matter
    req_data[31:24] = 8'h7F;
    req = 4'b1000;
    push_op(3, 8'h7F);
    wait_gnt(3);
    req = 4'b0000;
    hold = 1'b1;
    req_data[31:24] = 8'h00;
    exp_lat = 5;
    repeat (4) tick();
    check("hold_busy_no_rsp", 32'(rsp_valid), 0);
    hold = 1'b0;
    wait_rsp(3);
    exp_lat = 1;
    tick();

    // Hold in IDLE blocks arbitration until released
    hold = 1'b1;
    req_data[15:8] = 8'h10;
    req = 4'b0010;
    repeat (3) tick();
    check("hold_idle_no_gnt", 32'(gnt), 0);
    push_op(1, 8'h10);
    hold = 1'b0;
    c0 = cyc;
    wait_gnt(3);
    check("hold_idle_gnt_lat", last_gnt_cyc, c0 + 1);
    req = 4'b0000;
    wait_rsp(3);
    tick();

    // Withdrawal while requester 0 is serviced
    req_data[7:0] = 8'h05;
    req = 4'b0001;
    push_op(0, 8'h05);
    wait_gnt(3);
    req = 4'b0010;
    wait_rsp(3);
    check("withdraw_err_before", 32'(err), 0);
    req = 4'b0000;
    tick();
    check("withdraw_err_set", 32'(err), 1);
    repeat (3) tick();
    check("withdraw_err_sticky", 32'(err), 1);

    // Reset mid-BUSY drops the operation and restarts the pointer at 0
    req_data[23:16] = 8'h33;
    req = 4'b0100;
    exp_gnt.push_back(4'b0100);
    wait_gnt(3);
    req = 4'b0000;
    reset_n = 1'b0;
    #1;
    check("midrst_gnt", 32'(gnt), 0);
    check("midrst_rsp_valid", 32'(rsp_valid), 0);
    check("midrst_rsp_id", 32'(rsp_id), 0);
    check("midrst_rsp_data", 32'(rsp_data), 0);
    check("midrst_rsp_wrap", 32'(rsp_wrap), 0);
    check("midrst_err", 32'(err), 0);
    tick();
    reset_n = 1'b1;
    repeat (3) tick();
    req_data[7:0] = 8'h20;
    req_data[31:24] = 8'h30;
    req = 4'b1001;
    push_op(0, 8'h20);
    push_op(3, 8'h30);
    wait_gnt(3);
    req = 4'b1000;
    wait_gnt(5);
    req = 4'b0000;
    wait_rsp(3);
    tick();

    // Withdrawal with detection masked
    disable_error = 1'b1;
    req_data[7:0] = 8'h05;
    req = 4'b0001;
    push_op(0, 8'h05);
    wait_gnt(3);
    req = 4'b0010;
    wait_rsp(3);
    req = 4'b0000;
    repeat (3) tick();
    check("masked_err", 32'(err), 0);
    disable_error = 1'b0;
    tick();
    check("masked_err_after", 32'(err), 0);

    check("gnt_queue_empty", exp_gnt.size(), 0);
    check("rsp_queue_empty", exp_rsp.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_incr_scheduler.md
Name: rr_incr_scheduler

Overview:
- Round-robin scheduler that shares one registered increment unit (result = operand + 1) between NREQ requesters.
- Each requester posts an operand and holds a request. The block grants one requester at a time, sequences the shared unit through issue, execute and respond, and returns the result tagged with the requester id.
- A protocol checker flags requesters that withdraw a pending request. Checking can be masked by disable_error.
- Sits in front of the shared r1/r2-style increment register path.

Parameters:
NREQ, 4, number of requesters (2..8)
WIDTH, 8, operand/result width in bits
IDW, $clog2(NREQ), width of requester id

Ports:
clock  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
req  input  NREQ  per-requester request, level, held until granted
req_data  input  NREQ*WIDTH  operands; requester i uses bits [i*WIDTH +: WIDTH]
hold  input  1  stall: freezes the IDLE->BUSY and BUSY->DONE transitions
disable_error  input  1  suppresses protocol-violation detection
gnt  output  NREQ  one-hot grant pulse (registered), one cycle
rsp_valid  output  1  result valid, one-cycle pulse
rsp_id  output  IDW  id of the requester owning the result
rsp_data  output  WIDTH  operand + 1, modulo 2^WIDTH
rsp_wrap  output  1  high with rsp_valid when the operand was all-ones
err  output  1  sticky protocol-violation flag

Behaviour:
Reset (reset_n=0, takes effect asynchronously):
- State=IDLE, rr pointer=0.
- gnt=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_wrap=0, err=0.
- Reset asserted mid-operation drops the in-flight operation; no response is produced.

FSM states: IDLE, BUSY, DONE.
- IDLE, |req==1 and hold==0:
  - Winner = first i with req[i]==1, scanning from ptr upward with wrap past NREQ-1 to 0.
  - Latch winner id and req_data[winner].
  - gnt[winner]=1 on the next cycle only.
  - Go to BUSY.
- IDLE, req==0 or hold==1: stay in IDLE, gnt=0.
- BUSY, hold==0:
  - Register latched operand + 1, truncated to WIDTH; set wrap = (operand == all-ones).
  - Go to DONE.
- BUSY, hold==1: stay in BUSY; the latched operand is preserved.
- DONE:
  - rsp_valid=1 for exactly one cycle, with rsp_id, rsp_data and rsp_wrap.
  - ptr = (winner + 1) mod NREQ.
  - Always go to IDLE; hold is ignored in DONE.
- rsp_id, rsp_data and rsp_wrap keep their last values while rsp_valid=0.

Timing and throughput:
- Min latency: request sampled in IDLE at cycle T -> gnt at T+1 -> rsp_valid at T+2.
- Max throughput: one operation per 3 cycles.
- Next arbitration can happen in the cycle after rsp_valid.

Requester rules:
- A granted requester may keep req high to queue another operation. That request is arbitrated in the next IDLE, with the rotated pointer deciding priority.
- The operand is captured at arbitration. Later changes to req_data do not affect the in-flight result.

Protocol checker:
- Violation: req[i] was 1 in cycle t-1, is 0 in cycle t, and requester i was not granted in cycle t-1 or t. gnt[i] marks the grant cycle.
- On a violation with disable_error==0, err is set the next cycle and stays 1 until reset.
- disable_error==1 only masks new detection. It does not clear err.

Boundary rules:
- All req high: strict rotation 0,1,2,3,0,...
- Single requester: serviced back-to-back every 3 cycles.
- NREQ-1 -> 0 pointer wrap must be correct for non-power-of-two NREQ.

Test Plan:
- Single: req=0001, data0=8'h41 -> gnt=0001 at T+1; rsp_valid at T+2 with id=0, data=8'h42, wrap=0.
- All four requesting continuously, data_i=i*16 -> grant order 0,1,2,3,0; responses 01,11,21,31 at 3-cycle spacing; gnt always one-hot.
- Wrap: data2=8'hFF, req=0100 -> rsp_data=8'h00, rsp_wrap=1, rsp_id=2.
- Hold: assert hold for 4 cycles while in BUSY -> rsp_valid delayed exactly 4 cycles, correct data; hold during IDLE with req pending -> no gnt until hold drops.
- Withdrawal: req1 high 2 cycles while req0 is being serviced, then dropped before gnt1 -> err=1 next cycle and stays 1. Repeat with disable_error=1 -> err stays 0.
- Reset mid-BUSY: reset_n low 1 cycle -> all outputs 0 immediately; no rsp_valid; the next arbitration starts from ptr=0.
